// File: rtl/encrypter_v2_pkg.sv
// Shared types and index math for the v2 encrypter permutation stages.
// perm_idx is the single definition of the forward bit mapping P(i).
package encrypter_v2_pkg;

    localparam int BLOCK_W    = 64;
    localparam int IDX_W      = 6;
    localparam int DEF_MULT   = 29;
    localparam int DEF_OFFSET = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // P(i) = (mult*i + offset) mod 64; the product is truncated to the index width.
    function automatic logic [IDX_W-1:0] perm_idx(input logic [IDX_W-1:0] i,
                                                  input int unsigned       mult,
                                                  input int unsigned       offset);
        logic [31:0] full;
        full = (32'(i) * mult) + offset;
        return full[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/permute_chunk_gather.sv
// Combinational gather of one CHUNK-wide slice of the permuted block.
// Output bit b of chunk k is block[P(k*CHUNK + b)].
module permute_chunk_gather
    import encrypter_v2_pkg::*;
#(
    parameter int CHUNK  = 8,
    parameter int MULT   = DEF_MULT,
    parameter int OFFSET = DEF_OFFSET
) (
    input  logic [0:BLOCK_W-1] i_block,
    input  logic [IDX_W-1:0]   i_chunk_idx,
    output logic [0:CHUNK-1]   o_bits
);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        o_bits = '0;
        for (int b = 0; b < CHUNK; b++) begin
            o_bits[b] = i_block[perm_idx(IDX_W'((32'(i_chunk_idx) * CHUNK) + b), MULT, OFFSET)];
        end
    end

endmodule

// File: rtl/permute_map.sv
// Forward bit-permutation stage: captures a block on set, builds the permuted
// block CHUNK bits per cycle, then publishes it with a done flag.
module permute_map
    import encrypter_v2_pkg::*;
#(
    parameter int CHUNK  = 8,
    parameter int MULT   = DEF_MULT,
    parameter int OFFSET = DEF_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic [0:BLOCK_W-1] data_in,
    output logic               status,
    output logic [0:BLOCK_W-1] data_out
);

    localparam int N = BLOCK_W / CHUNK;

    generate
        if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 || CHUNK == 8 ||
              CHUNK == 16 || CHUNK == 32 || CHUNK == 64)) begin : g_bad_chunk
            $error("permute_map: CHUNK must be a power of two in 1..64");
        end
        if ((MULT % 2) == 0) begin : g_bad_mult
            $error("permute_map: MULT must be odd for the mapping to be a bijection");
        end
        if (OFFSET < 0 || OFFSET > 63) begin : g_bad_offset
            $error("permute_map: OFFSET must lie in 0..63");
        end
    endgenerate

    state_e             r_state;
    state_e             w_state_next;
    logic [IDX_W-1:0]   r_count;
    logic [0:BLOCK_W-1] r_capture;
    logic [0:BLOCK_W-1] r_shadow;
    logic [0:BLOCK_W-1] r_data_out;
    logic               r_status;

    logic               w_capture;
    logic               w_step;
    logic               w_last;
    logic [0:CHUNK-1]   w_chunk;
    logic [0:BLOCK_W-1] w_shadow_next;

    permute_chunk_gather #(
        .CHUNK  (CHUNK),
        .MULT   (MULT),
        .OFFSET (OFFSET)
    ) u_gather (
        .i_block     (r_capture),
        .i_chunk_idx (r_count),
        .o_bits      (w_chunk)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (set) begin
                    w_capture    = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_count == IDX_W'(N - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shadow with the current chunk merged, so the final edge can publish it directly.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int b = 0; b < BLOCK_W; b++) begin
            if ((b / CHUNK) == int'(r_count)) begin
                w_shadow_next[b] = w_chunk[b % CHUNK];
            end
        end
    end

    // NOTE: sequential state is assigned with <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the capture and shadow registers are reset too, so no X can reach data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_capture  <= '0;
            r_shadow   <= '0;
            r_data_out <= '0;
            r_status   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_capture <= data_in;
                r_count   <= '0;
                r_status  <= 1'b0;
            end
            if (w_step) begin
                r_shadow <= w_shadow_next;
                r_count  <= r_count + 1'b1;
            end
            if (w_last) begin
                r_data_out <= w_shadow_next;
                r_status   <= 1'b1;
                r_count    <= '0;
            end
        end
    end

    assign status   = r_status;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_permute_map.sv
// Self-checking bench for permute_map: directed scenarios plus random blocks,
// compared against a plain-arithmetic model of the permutation.
module tb_permute_map;
    import encrypter_v2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        set0, set1, set2;
    logic [0:63] din0, din1, din2;
    logic        st0, st1, st2;
    logic [0:63] do0, do1, do2;

    int vectors     = 0;
    int miscompares = 0;
    logic [0:63] exp_out [3];
    int chunk_of [3] = '{8, 1, 64};

    permute_map #(.CHUNK(8))  u_c8  (.clk(clk), .rst(rst), .set(set0), .data_in(din0), .status(st0), .data_out(do0));
    permute_map #(.CHUNK(1))  u_c1  (.clk(clk), .rst(rst), .set(set1), .data_in(din1), .status(st1), .data_out(do1));
    permute_map #(.CHUNK(64)) u_c64 (.clk(clk), .rst(rst), .set(set2), .data_in(din2), .status(st2), .data_out(do2));

    // Forward model straight from the definition: out[i] = in[(29*i + 7) mod 64].
    function automatic logic [0:63] model(input logic [0:63] d);
        logic [0:63] r;
        for (int i = 0; i < 64; i++) r[i] = d[(29 * i + 7) % 64];
        return r;
    endfunction

    // Decrypt-side inverse: in[j] = out[53*(j-7) mod 64].
    function automatic logic [0:63] inverse(input logic [0:63] o);
        logic [0:63] r;
        for (int j = 0; j < 64; j++) r[j] = o[(((53 * (j - 7)) % 64) + 64) % 64];
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic s, input logic [0:63] d);
        case (u)
            0: begin set0 = s; din0 = d; end
            1: begin set1 = s; din1 = d; end
            default: begin set2 = s; din2 = d; end
        endcase
    endtask

    function automatic logic get_st(input int u);
        case (u)
            0: return st0;
            1: return st1;
            default: return st2;
        endcase
    endfunction

    function automatic logic [0:63] get_do(input int u);
        case (u)
            0: return do0;
            1: return do1;
            default: return do2;
        endcase
    endfunction

    // Full run on unit u: busy for N-1 edges after capture, done at edge N.
    task automatic run_block(input int u, input logic [0:63] d, input string tag);
        int n;
        n = 64 / chunk_of[u];
        drive(u, 1'b1, d);
        tick();
        check({tag, " status@E0"}, 64'(get_st(u)), 64'd0);
        check({tag, " hold@E0"}, get_do(u), exp_out[u]);
        for (int k = 1; k < n; k++) begin
            drive(u, 1'b0, rand64());
            tick();
            check({tag, " busy"}, 64'(get_st(u)), 64'd0);
            check({tag, " hold"}, get_do(u), exp_out[u]);
        end
        drive(u, 1'b0, rand64());
        tick();
        exp_out[u] = model(d);
        check({tag, " done"}, 64'(get_st(u)), 64'd1);
        check({tag, " data"}, get_do(u), exp_out[u]);
    endtask

    initial begin
        logic [0:63] va, vb, vv;
        logic [0:63] dv [18];

        // Reset has priority over set.
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            drive(u, 1'b1, rand64());
            exp_out[u] = '0;
        end
        for (int e = 0; e < 2; e++) begin
            tick();
            for (int u = 0; u < 3; u++) begin
                check("rst status", 64'(get_st(u)), 64'd0);
                check("rst data", get_do(u), 64'd0);
            end
        end
        rst = 1'b0;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, rand64());
        for (int e = 0; e < 10; e++) begin
            tick();
            check("idle status", 64'(st0), 64'd0);
            check("idle data", do0, 64'd0);
        end

        // Single-bit and constant blocks.
        run_block(0, 64'h8000_0000_0000_0000, "c8 bit0");
        check("c8 bit0 const", do0, 64'h0004_0000_0000_0000);
        run_block(0, 64'h0100_0000_0000_0000, "c8 bit7");
        check("c8 bit7 const", do0, 64'h8000_0000_0000_0000);
        run_block(0, 64'hffff_ffff_ffff_ffff, "c8 ones");
        check("c8 ones const", do0, 64'hffff_ffff_ffff_ffff);
        run_block(0, 64'h0, "c8 zero");
        check("c8 zero const", do0, 64'h0);

        // Reference vector: permutation, popcount and round trip.
        vv = 64'h5e27c71d8913a53a;
        run_block(0, vv, "c8 vec");
        check("vec popcount", 64'($countones(do0)), 64'($countones(vv)));
        check("vec inverse", inverse(do0), 64'h5e27c71d8913a53a);

        // set re-pulsed and data_in changed mid-run are ignored.
        va = rand64();
        vb = ~va;
        drive(0, 1'b1, va);
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) drive(0, 1'b1, vb);
            else        drive(0, 1'b0, rand64());
            tick();
            if (k < 8) begin
                check("intf busy", 64'(st0), 64'd0);
                check("intf hold", do0, exp_out[0]);
            end
        end
        exp_out[0] = model(va);
        check("intf done", 64'(st0), 64'd1);
        check("intf data", do0, exp_out[0]);

        // Reset mid-run aborts with no output update.
        drive(0, 1'b1, rand64());
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1'b0, rand64());
            if (k == 5) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        for (int u = 0; u < 3; u++) exp_out[u] = '0;
        check("abort status", 64'(st0), 64'd0);
        check("abort data", do0, 64'd0);
        run_block(0, rand64(), "c8 after abort");

        // set held high: one-cycle done pulse per block, 9 edges apart.
        for (int e = 0; e < 18; e++) dv[e] = rand64();
        for (int e = 0; e < 18; e++) begin
            drive(0, 1'b1, dv[e]);
            tick();
            check("b2b status", 64'(st0), (e == 8 || e == 17) ? 64'd1 : 64'd0);
            if (e < 8)       check("b2b data", do0, exp_out[0]);
            else if (e < 17) check("b2b data", do0, model(dv[0]));
            else             check("b2b data", do0, model(dv[9]));
        end
        drive(0, 1'b0, rand64());
        exp_out[0] = model(dv[9]);

        // Other chunk widths.
        run_block(1, 64'h8000_0000_0000_0000, "c1 bit0");
        check("c1 bit0 const", do1, 64'h0004_0000_0000_0000);
        run_block(2, 64'h8000_0000_0000_0000, "c64 bit0");
        check("c64 bit0 const", do2, 64'h0004_0000_0000_0000);

        // Random blocks on every width.
        for (int r = 0; r < 6; r++) begin
            for (int u = 0; u < 3; u++) run_block(u, rand64(), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
